// File: rtl/mmio_console.sv
// mmio_console: memory-mapped character output port for the cpu32 data bus.
// The CPU stores characters into a TX FIFO. A rate-paced valid/ready port then
// drains the FIFO into a sink. The block also provides readable status, a sticky
// overflow flag, a flush control and an empty interrupt.
//
// Ports:
//   clk, reset_n        clock (rising edge) and asynchronous active-low reset
//   cs, we, addr, wdata bus slave inputs; addr selects DATA/STATUS (0) or CTRL/COUNT (1)
//   rdata               combinational read data, 0 when cs=0
//   tx_valid, tx_data   head character towards the sink; tx_data is 0 when tx_valid=0
//   tx_ready            sink accepts; a transfer happens on tx_valid & tx_ready
//   irq                 level interrupt: FIFO empty and IE set
//
// Optional feature: define CONSOLE_SIM_PRINT_EN to echo each accepted character
// to the simulator console. With the macro undefined, the block is fully synthesizable.
module mmio_console #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned PACE   = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cs,
    input  logic              we,
    input  logic              addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              tx_valid,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_ready,
    output logic              irq
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned PACE_W = (PACE > 0) ? $clog2(PACE + 1) : 1;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic [PACE_W-1:0] pace_q,   pace_d;
    logic              ovf_q,    ovf_d;
    logic              ie_q,     ie_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic empty, full, pop, push_req, push_ok, ctrl_wr, flush;

    // Upper write-data bits are don't-care when DATA_W < 32.
    logic unused_wdata;
    assign unused_wdata = ^wdata;

    // Bus decode and handshake qualifiers.
    always_comb begin
        empty    = (count_q == CNT_W'(0));
        full     = (count_q == CNT_W'(DEPTH));
        tx_valid = !empty && (pace_q == PACE_W'(0));
        pop      = tx_valid && tx_ready;
        push_req = cs && we && !addr;
        ctrl_wr  = cs && we && addr;
        flush    = ctrl_wr && wdata[1];
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push_ok  = push_req && (!full || pop) && !flush;
    end

    // Next-state computation for pointers, occupancy, pacing and control bits.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pace_d   = pace_q;
        ovf_d    = ovf_q;
        ie_d     = ie_q;

        if (flush) begin
            wr_ptr_d = PTR_W'(0);
            rd_ptr_d = PTR_W'(0);
            count_d  = CNT_W'(0);
            pace_d   = PACE_W'(0);
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push_ok && !pop)      count_d = count_q + CNT_W'(1);
            else if (!push_ok && pop) count_d = count_q - CNT_W'(1);

            if (pop)                         pace_d = PACE_W'(PACE);
            else if (pace_q != PACE_W'(0))   pace_d = pace_q - PACE_W'(1);
        end

        // The clear is applied first so that a simultaneous set takes priority.
        if (ctrl_wr && wdata[0]) ovf_d = 1'b0;
        if (push_req && full && !pop && !flush) ovf_d = 1'b1;

        if (ctrl_wr) ie_d = wdata[2];
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            pace_q   <= '0;
            ovf_q    <= 1'b0;
            ie_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            pace_q   <= pace_d;
            ovf_q    <= ovf_d;
            ie_q     <= ie_d;
        end
    end

    // Storage array. It has no reset because occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata[DATA_W-1:0];
    end

    // Output side: head character, interrupt and register read mux.
    always_comb begin
        tx_data = tx_valid ? mem_q[rd_ptr_q] : '0;
        irq     = empty && ie_q;
        rdata   = 32'(0);
        if (cs) begin
            if (addr) rdata = 32'(count_q);
            else      rdata = {28'b0, ovf_q, ie_q, full, empty};
        end
    end

`ifdef CONSOLE_SIM_PRINT_EN
    logic [31:0] print_word;
    assign print_word = 32'(tx_data);

    always @(posedge clk) begin
        if (reset_n && pop) $write("%c", print_word[7:0]);
    end
`else
`endif

endmodule

// File: tb/tb_mmio_console.sv
module tb_mmio_console;

    localparam int unsigned DEPTH = 4;
    localparam int NI = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic cs = 1'b0, we = 1'b0, addr = 1'b0, tx_ready = 1'b0;
    logic [31:0] wdata = 32'h0;

    logic [31:0] rdata    [NI];
    logic        tx_valid [NI];
    logic [7:0]  tx_data  [NI];
    logic        irq      [NI];

    always #5 clk = ~clk;

    // Two DUTs share the bus stimulus: one runs back-to-back, the other is paced.
    mmio_console #(.DATA_W(8), .DEPTH(DEPTH), .PACE(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .cs(cs), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata[0]), .tx_valid(tx_valid[0]), .tx_data(tx_data[0]),
        .tx_ready(tx_ready), .irq(irq[0])
    );

    mmio_console #(.DATA_W(8), .DEPTH(DEPTH), .PACE(3)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .cs(cs), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata[1]), .tx_valid(tx_valid[1]), .tx_data(tx_data[1]),
        .tx_ready(tx_ready), .irq(irq[1])
    );

    // Reference model: a character queue plus the flag and pace state of each instance.
    int          m_pace_cfg [NI] = '{0, 3};
    logic [7:0]  m_fifo [NI][$];
    int          m_pace [NI];
    bit          m_ovf  [NI];
    bit          m_ie   [NI];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_valid(input int k);
        return (m_fifo[k].size() != 0) && (m_pace[k] == 0);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            m_fifo[k].delete();
            m_pace[k] = 0;
            m_ovf[k]  = 1'b0;
            m_ie[k]   = 1'b0;
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < NI; k++) begin
            int sz;
            bit v;
            logic [31:0] exp_rd;
            logic [7:0]  exp_d;
            sz = m_fifo[k].size();
            v  = m_valid(k);
            exp_d = v ? m_fifo[k][0] : 8'h00;
            if (!cs)       exp_rd = 32'h0;
            else if (addr) exp_rd = 32'(sz);
            else exp_rd = {28'b0, m_ovf[k], m_ie[k], (sz == int'(DEPTH)), (sz == 0)};
            check($sformatf("u%0d.tx_valid", k), 32'(tx_valid[k]), 32'(v));
            check($sformatf("u%0d.tx_data", k),  32'(tx_data[k]),  32'(exp_d));
            check($sformatf("u%0d.irq", k),      32'(irq[k]),      32'((sz == 0) && m_ie[k]));
            check($sformatf("u%0d.rdata", k),    rdata[k],         exp_rd);
        end
    endtask

    // Advances each model by one clock edge, using the inputs held across that edge.
    task automatic model_update();
        for (int k = 0; k < NI; k++) begin
            bit pop, push, ctrl;
            int pre;
            pre  = m_fifo[k].size();
            pop  = m_valid(k) && tx_ready;
            push = cs && we && !addr;
            ctrl = cs && we && addr;
            if (ctrl && wdata[1]) begin
                m_fifo[k].delete();
                m_pace[k] = 0;
            end else begin
                if (pop) begin
                    void'(m_fifo[k].pop_front());
                    m_pace[k] = m_pace_cfg[k];
                end else if (m_pace[k] > 0) begin
                    m_pace[k]--;
                end
                if (push) begin
                    if (pre == int'(DEPTH) && !pop) m_ovf[k] = 1'b1;
                    else m_fifo[k].push_back(wdata[7:0]);
                end
            end
            if (ctrl) begin
                if (wdata[0]) m_ovf[k] = 1'b0;
                m_ie[k] = wdata[2];
            end
        end
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic tick();
        #1;
        check_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic bus(input logic c, input logic w, input logic a,
                       input logic [31:0] d, input logic rdy);
        cs = c; we = w; addr = a; wdata = d; tx_ready = rdy;
        tick();
    endtask

    // Asserts reset in the middle of a low clock phase and checks that the outputs clear immediately.
    task automatic do_reset();
        cs = 1'b1; we = 1'b0; addr = 1'b1; wdata = 32'h0;
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        @(negedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        reset_n = 1'b1;

        // Two back-to-back characters into an idle sink.
        bus(1, 1, 0, 32'h48, 1);
        bus(1, 1, 0, 32'h69, 1);
        for (int i = 0; i < 10; i++) bus(0, 0, 0, 0, 1);
        bus(1, 0, 0, 0, 1);

        // Overfill with the sink stalled, then drain.
        for (int i = 0; i < 5; i++) bus(1, 1, 0, 32'h61 + 32'(i), 0);
        bus(1, 0, 1, 0, 0);
        bus(1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) bus(0, 0, 0, 0, 1);

        // Full FIFO with a push in the same cycle as a pop.
        bus(1, 1, 1, 32'h1, 0);
        for (int i = 0; i < 4; i++) bus(1, 1, 0, 32'h30 + 32'(i), 0);
        bus(1, 1, 0, 32'h7a, 1);
        bus(1, 0, 1, 0, 1);
        bus(1, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++) bus(0, 0, 0, 0, 1);

        // Paced drain of three characters, observed on the paced instance.
        for (int i = 0; i < 3; i++) bus(1, 1, 0, 32'h41 + 32'(i), 0);
        for (int i = 0; i < 14; i++) bus(0, 0, 0, 0, 1);

        // Empty interrupt, then a flush with IE set.
        bus(1, 1, 1, 32'h4, 0);
        bus(0, 0, 0, 0, 0);
        bus(1, 1, 0, 32'h78, 0);
        bus(1, 1, 0, 32'h79, 0);
        bus(1, 1, 0, 32'h7a, 0);
        bus(1, 1, 1, 32'h6, 1);
        bus(1, 0, 1, 0, 1);
        bus(1, 1, 1, 32'h0, 1);

        // Reset in the middle of a stalled transfer.
        bus(1, 1, 0, 32'h51, 0);
        bus(1, 1, 0, 32'h52, 0);
        do_reset();
        for (int i = 0; i < 4; i++) bus(0, 0, 0, 0, 1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) < 2) begin
                do_reset();
            end else begin
                cs       = ($urandom_range(0, 3) != 0);
                we       = ($urandom_range(0, 2) != 0);
                addr     = ($urandom_range(0, 4) == 0);
                wdata    = $urandom;
                tx_ready = ($urandom_range(0, 2) != 0);
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
